fifo_wr_arbiter: RTL and testbench

- Shares the write port of the async FIFO (winc/wdata/wfull) between N_REQ producer channels in the write-clock domain.
- Each channel requests a burst of 1..MAX_LEN words. The block grants round-robin and holds the grant for the whole burst, so one packet's words are never interleaved with another's.
- Sits between the producer engines and FIFO_syn; it is instantiated on the wclk side.

---
 rtl/fifo_arb_pkg.sv | 23 ++
 rtl/fifo_wr_arbiter_rr_pick.sv | 37 +++
 rtl/fifo_wr_arbiter.sv | 126 ++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_arb_pkg.sv
// rtl/fifo_arb_pkg.sv - shared types and width helpers for the FIFO write arbiter
//
// Purpose: arbiter FSM state type and the width functions used to size the
// length field and the grant index.

package fifo_arb_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    XFER = 1'b1
  } state_t;

  // Width of one burst length field (length is stored as words-1).
  function automatic int len_w(input int max_len);
    return (max_len > 1) ? $clog2(max_len) : 1;
  endfunction

  // Width of a channel index; never zero so a 1-bit port always exists.
  function automatic int idx_w(input int n_req);
    return (n_req > 1) ? $clog2(n_req) : 1;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// rtl/fifo_wr_arbiter_rr_pick.sv - combinational round-robin priority selector
//
// Purpose: finds the first asserted request scanning upward from
// last_grant+1, wrapping modulo N_REQ, so last_grant itself is checked last.
// Ports:
//   req         in   N_REQ  request vector
//   last_grant  in   IDX_W  most recently granted channel (must be < N_REQ)
//   pick        out  IDX_W  selected channel, 0 when nothing requests
//   any         out  1      at least one request is asserted

module rr_pick #(
  parameter int N_REQ = 3,
  parameter int IDX_W = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] last_grant,
  output logic [IDX_W-1:0] pick,
  output logic             any
);

  logic [IDX_W-1:0] idx;

  always_comb begin
    pick = '0;
    any  = 1'b0;
    idx  = last_grant;
    for (int off = 0; off < N_REQ; off++) begin
      // Explicit wrap keeps the scan modulo N_REQ rather than 2^IDX_W.
      idx = (idx == IDX_W'(N_REQ - 1)) ? '0 : idx + IDX_W'(1);
      if (!any && req[idx]) begin
        any  = 1'b1;
        pick = idx;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin burst arbiter for the async FIFO write port
//
// Purpose: shares winc/wdata/wfull between N_REQ producer channels. A grant is
// held for the whole burst so packets never interleave.
// Ports:
//   clk       in   1            write-domain clock (FIFO wclk)
//   rst_n     in   1            asynchronous active-low reset
//   req       in   N_REQ        per-channel burst request, held until last ack
//   len       in   N_REQ*LEN_W  per-channel burst length-1, sampled at grant
//   data      in   N_REQ*WIDTH  per-channel current word, stable until acked
//   ack       out  N_REQ        one-hot: channel's current word written this cycle
//   winc      out  1            FIFO write request
//   wdata     out  WIDTH        FIFO write data
//   wfull     in   1            FIFO full flag
//   busy      out  1            burst in progress
//   grant_id  out  IDX_W        current or last granted channel
//   pkt_done  out  1            pulse on the accepted last word of a burst
//   abort     out  1            pulse when a burst ends because req dropped

module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int N_REQ   = 3,
  parameter int WIDTH   = 8,
  parameter int MAX_LEN = 16,
  parameter int LEN_W   = len_w(MAX_LEN),
  localparam int IDX_W  = idx_w(N_REQ)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*LEN_W-1:0] len,
  input  logic [N_REQ*WIDTH-1:0] data,
  output logic [N_REQ-1:0]       ack,
  output logic                   winc,
  output logic [WIDTH-1:0]       wdata,
  input  logic                   wfull,
  output logic                   busy,
  output logic [IDX_W-1:0]       grant_id,
  output logic                   pkt_done,
  output logic                   abort
);

  state_t           state, state_next;
  logic [LEN_W-1:0] cnt, cnt_next;
  logic [IDX_W-1:0] grant_next;
  logic [IDX_W-1:0] last_grant, last_next;
  logic [IDX_W-1:0] pick;
  logic             any;
  logic             accept;

  rr_pick #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_rr_pick (
    .req        (req),
    .last_grant (last_grant),
    .pick       (pick),
    .any        (any)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      grant_id   <= '0;
      // Channel 0 must win the first arbitration after reset.
      last_grant <= IDX_W'(N_REQ - 1);
    end else begin
      state      <= state_next;
      cnt        <= cnt_next;
      grant_id   <= grant_next;
      last_grant <= last_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    grant_next = grant_id;
    last_next  = last_grant;
    winc       = 1'b0;
    busy       = 1'b0;
    wdata      = '0;
    ack        = '0;
    pkt_done   = 1'b0;
    abort      = 1'b0;
    accept     = 1'b0;

    case (state)
      IDLE: begin
        if (any) begin
          grant_next = pick;
          cnt_next   = len[int'(pick)*LEN_W +: LEN_W];
          state_next = XFER;
        end
      end

      XFER: begin
        // winc stays high through wfull; the FIFO gates the write itself.
        winc   = 1'b1;
        busy   = 1'b1;
        wdata  = data[int'(grant_id)*WIDTH +: WIDTH];
        accept = winc & ~wfull;
        if (accept) begin
          ack[grant_id] = 1'b1;
          if (cnt == '0) begin
            pkt_done   = 1'b1;
            last_next  = grant_id;
            state_next = IDLE;
          end else begin
            cnt_next = cnt - LEN_W'(1);
          end
        end else if (!req[grant_id]) begin
          // A word written this cycle wins over a dropped request.
          abort      = 1'b1;
          last_next  = grant_id;
          state_next = IDLE;
        end
      end

      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb/tb_fifo_wr_arbiter.sv - directed self-checking bench for fifo_wr_arbiter

module tb_fifo_wr_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  req;
  logic [11:0] len;
  logic [23:0] data;
  logic [2:0]  ack;
  logic        winc;
  logic [7:0]  wdata;
  logic        wfull;
  logic        busy;
  logic [1:0]  grant_id;
  logic        pkt_done;
  logic        abort;

  int checks   = 0;
  int failures = 0;
  logic [7:0] fifo_q[$];

  fifo_wr_arbiter #(
    .N_REQ   (3),
    .WIDTH   (8),
    .MAX_LEN (16)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .len      (len),
    .data     (data),
    .ack      (ack),
    .winc     (winc),
    .wdata    (wdata),
    .wfull    (wfull),
    .busy     (busy),
    .grant_id (grant_id),
    .pkt_done (pkt_done),
    .abort    (abort)
  );

  always #5 clk = ~clk;

  // FIFO model: records every word the FIFO would actually store.
  always @(negedge clk) begin
    if (rst_n && winc && !wfull) fifo_q.push_back(wdata);
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Start of a new cycle: inputs for it are driven after this returns.
  task automatic cyc;
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst_n = 1'b0;
    req   = '0;
    len   = '0;
    data  = '0;
    wfull = 1'b0;

    // Reset state
    cyc;
    cyc;
    #1;
    chk("rst_winc", winc, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ack", ack, 0);
    chk("rst_grant", grant_id, 0);
    chk("rst_wdata", wdata, 0);
    chk("rst_pkt_done", pkt_done, 0);
    chk("rst_abort", abort, 0);

    // Round robin, single-word bursts: winc 0,1,0,1,0,1
    req  = 3'b111;
    data = 24'hA2_A1_A0;
    rst_n = 1'b1;
    #1;
    chk("rr_c0_winc", winc, 0);
    cyc; #1;
    chk("rr_c1_winc", winc, 1);
    chk("rr_c1_grant", grant_id, 0);
    chk("rr_c1_ack", ack, 3'b001);
    chk("rr_c1_wdata", wdata, 8'hA0);
    chk("rr_c1_done", pkt_done, 1);
    cyc; #1;
    chk("rr_c2_winc", winc, 0);
    chk("rr_c2_wdata", wdata, 0);
    cyc; #1;
    chk("rr_c3_winc", winc, 1);
    chk("rr_c3_grant", grant_id, 1);
    chk("rr_c3_ack", ack, 3'b010);
    chk("rr_c3_wdata", wdata, 8'hA1);
    cyc; #1;
    chk("rr_c4_winc", winc, 0);
    cyc; #1;
    chk("rr_c5_winc", winc, 1);
    chk("rr_c5_grant", grant_id, 2);
    chk("rr_c5_ack", ack, 3'b100);
    cyc; #1;
    chk("rr_c6_winc", winc, 0);
    cyc; #1;
    chk("rr_c7_grant", grant_id, 0);
    chk("rr_c7_ack", ack, 3'b001);
    cyc;
    req = 3'b000;
    #1;
    chk("rr_c8_winc", winc, 0);

    // ch1 four-word burst, no backpressure
    cyc;
    req = 3'b010;
    len = 12'h030;
    data[15:8] = 8'h10;
    #1;
    chk("b4_arb_winc", winc, 0);
    for (int k = 0; k < 4; k++) begin
      cyc;
      data[15:8] = 8'h10 + 8'(k);
      #1;
      chk("b4_ack", ack, 3'b010);
      chk("b4_wdata", wdata, 8'h10 + 8'(k));
      chk("b4_busy", busy, 1);
      chk("b4_done", pkt_done, (k == 3) ? 1 : 0);
    end
    cyc;
    req = 3'b000;
    #1;
    chk("b4_end_busy", busy, 0);
    chk("b4_end_winc", winc, 0);

    // Same burst with a 5-cycle wfull stall after the 2nd word
    cyc;
    fifo_q.delete();
    req = 3'b010;
    data[15:8] = 8'h10;
    #1;
    chk("st_arb_winc", winc, 0);
    cyc; #1;
    chk("st_w0_ack", ack, 3'b010);
    chk("st_w0_wdata", wdata, 8'h10);
    cyc;
    data[15:8] = 8'h11;
    #1;
    chk("st_w1_ack", ack, 3'b010);
    chk("st_w1_wdata", wdata, 8'h11);
    for (int k = 0; k < 5; k++) begin
      cyc;
      data[15:8] = 8'h12;
      wfull = 1'b1;
      #1;
      chk("st_stall_ack", ack, 0);
      chk("st_stall_winc", winc, 1);
      chk("st_stall_busy", busy, 1);
    end
    cyc;
    wfull = 1'b0;
    #1;
    chk("st_w2_ack", ack, 3'b010);
    chk("st_w2_wdata", wdata, 8'h12);
    chk("st_w2_done", pkt_done, 0);
    cyc;
    data[15:8] = 8'h13;
    #1;
    chk("st_w3_ack", ack, 3'b010);
    chk("st_w3_wdata", wdata, 8'h13);
    chk("st_w3_done", pkt_done, 1);
    cyc;
    req = 3'b000;
    #1;
    chk("st_fifo_size", fifo_q.size(), 4);
    for (int k = 0; k < 4; k++) begin
      if (k < fifo_q.size()) chk("st_fifo_word", fifo_q[k], 8'h10 + 8'(k));
    end

    // ch2 burst of 8 aborted after 3 words; ch0 and ch1 pending
    cyc;
    fifo_q.delete();
    req = 3'b111;
    len = 12'h700;
    data[23:16] = 8'h20;
    data[7:0]   = 8'h05;
    #1;
    chk("ab_arb_winc", winc, 0);
    for (int k = 0; k < 3; k++) begin
      cyc;
      data[23:16] = 8'h20 + 8'(k);
      #1;
      chk("ab_grant", grant_id, 2);
      chk("ab_ack", ack, 3'b100);
      chk("ab_wdata", wdata, 8'h20 + 8'(k));
    end
    cyc;
    req = 3'b011;
    wfull = 1'b1;
    #1;
    chk("ab_abort", abort, 1);
    chk("ab_ack0", ack, 0);
    chk("ab_done0", pkt_done, 0);
    cyc;
    wfull = 1'b0;
    #1;
    chk("ab_after_busy", busy, 0);
    chk("ab_after_abort", abort, 0);
    chk("ab_fifo_size", fifo_q.size(), 3);
    cyc; #1;
    chk("ab_next_grant", grant_id, 0);
    chk("ab_next_ack", ack, 3'b001);
    chk("ab_next_wdata", wdata, 8'h05);
    cyc;
    req = 3'b000;
    #1;
    chk("ab_idle_winc", winc, 0);

    // Maximum length burst on ch0; len change mid-burst is ignored
    cyc;
    req = 3'b001;
    len = 12'h00F;
    data[7:0] = 8'h40;
    #1;
    chk("mx_arb_winc", winc, 0);
    for (int k = 0; k < 16; k++) begin
      cyc;
      data[7:0] = 8'h40 + 8'(k);
      if (k == 1) len = 12'h000;
      #1;
      chk("mx_ack", ack, 3'b001);
      chk("mx_done", pkt_done, (k == 15) ? 1 : 0);
    end
    cyc;
    req = 3'b000;
    #1;
    chk("mx_end_busy", busy, 0);

    // Asynchronous reset on word 2 of a ch0 burst
    cyc;
    req = 3'b001;
    len = 12'h003;
    data[7:0] = 8'h50;
    #1;
    cyc; #1;
    chk("rs_w0_ack", ack, 3'b001);
    cyc;
    data[7:0] = 8'h51;
    #1;
    chk("rs_w1_ack", ack, 3'b001);
    chk("rs_w1_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("rs_winc", winc, 0);
    chk("rs_ack", ack, 0);
    chk("rs_busy", busy, 0);
    chk("rs_wdata", wdata, 0);
    req = 3'b111;
    len = 12'h000;
    cyc;
    rst_n = 1'b1;
    #1;
    chk("rs_rel_winc", winc, 0);
    cyc; #1;
    chk("rs_first_grant", grant_id, 0);
    chk("rs_first_ack", ack, 3'b001);
    cyc;
    req = 3'b000;
    cyc;
    cyc;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
